// File: rtl/intlv_pkg.sv
// Shared types and defaults for the DVB-C interleaver sync controller.
// The interleaver geometry (I=12, M=17) fixes the default RS packet length.
package intlv_pkg;

    localparam int INTER_B = 12;
    localparam int INTER_M = 17;
    localparam int PKT_LEN_DEF = INTER_B * INTER_M;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'h47;
    localparam logic [7:0] SYNC_INV_DEF = 8'hB8;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCK
    } sync_state_t;

    // A one-value counter still needs a 1-bit register.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic is_sync_byte(input logic [7:0] b,
                                          input logic [7:0] sync_norm,
                                          input logic [7:0] sync_inv);
        return (b == sync_norm) || (b == sync_inv);
    endfunction

endpackage

// File: rtl/intlv_pace_gen.sv
// Symbol-rate pacing strobe: a free-running 0..RATE_DIV-1 counter whose
// terminal count is registered into a one-cycle ready pulse.
module intlv_pace_gen
    import intlv_pkg::*;
#(
    parameter int RATE_DIV = 4
) (
    input  logic clk,
    input  logic clrn,
    output logic ready
);

    localparam int CW = cnt_width(RATE_DIV);
    localparam logic [CW-1:0] PACE_LAST = CW'(RATE_DIV - 1);

    logic [CW-1:0] pace_cnt;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pace_cnt <= '0;
            ready    <= 1'b0;
        end else begin
            pace_cnt <= (pace_cnt == PACE_LAST) ? '0 : pace_cnt + 1'b1;
            ready    <= (pace_cnt == PACE_LAST);
        end
    end

endmodule

// File: rtl/intlv_sync_ctrl.sv
// Packet framer / pacing controller in front of the DVB-C convolutional
// interleaver. Optional statistics outputs: define INTLV_SYNC_CTRL_STATS_EN.
module intlv_sync_ctrl
    import intlv_pkg::*;
#(
    parameter int         PKT_LEN   = PKT_LEN_DEF,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter logic [7:0] SYNC_INV  = SYNC_INV_DEF,
    parameter int         LOCK_N    = 3,
    parameter int         UNLOCK_N  = 3,
    parameter int         RATE_DIV  = 4
) (
    input  logic       iClk,
    input  logic       iClrn,
    input  logic [7:0] iData,
    input  logic       iValid,
    output logic       oReady,
    output logic [7:0] oData,
    output logic       oValid,
    output logic       oPSync,
    output logic       oLock
`ifdef INTLV_SYNC_CTRL_STATS_EN
    ,
    output logic [15:0] oPktCnt,
    output logic [7:0]  oLossCnt
`endif
);

    localparam int PW = cnt_width(PKT_LEN);
    localparam int GW = cnt_width(LOCK_N + 1);
    localparam int BW = cnt_width(UNLOCK_N + 1);
    localparam logic [PW-1:0] POS_LAST  = PW'(PKT_LEN - 1);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_N - 1);
    localparam logic [BW-1:0] BAD_LAST  = BW'(UNLOCK_N - 1);

    sync_state_t   state, state_nxt;
    logic [PW-1:0] pos, pos_nxt, pos_inc;
    logic [GW-1:0] good_cnt, good_nxt;
    logic [BW-1:0] bad_cnt, bad_nxt;
    logic          ready;
    logic          accept;
    logic          sync_hit;
    logic          fwd;
    logic          psync;

    logic [7:0]    data_p1;
    logic          vld_p1;
    logic          psync_p1;
    logic          lock_p1;

    intlv_pace_gen #(
        .RATE_DIV(RATE_DIV)
    ) u_pace (
        .clk  (iClk),
        .clrn (iClrn),
        .ready(ready)
    );

    assign accept   = iValid & ready;
    assign sync_hit = is_sync_byte(iData, SYNC_BYTE, SYNC_INV);
    assign pos_inc  = (pos == POS_LAST) ? '0 : pos + 1'b1;

    always_ff @(posedge iClk or negedge iClrn) begin
        if (!iClrn) begin
            state    <= HUNT;
            pos      <= '0;
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            pos      <= pos_nxt;
            good_cnt <= good_nxt;
            bad_cnt  <= bad_nxt;
        end
    end

    // Only the byte at pos 0 can change the framing decision; all other
    // accepted bytes just advance the position (and are forwarded in LOCK).
    always_comb begin
        state_nxt = state;
        pos_nxt   = pos;
        good_nxt  = good_cnt;
        bad_nxt   = bad_cnt;
        fwd       = 1'b0;
        psync     = 1'b0;
        if (accept) begin
            case (state)
                HUNT: begin
                    if (sync_hit) begin
                        pos_nxt = PW'(1);
                        if (LOCK_N <= 1) begin
                            state_nxt = LOCK;
                            fwd       = 1'b1;
                            psync     = 1'b1;
                            bad_nxt   = '0;
                        end else begin
                            state_nxt = VERIFY;
                            good_nxt  = GW'(1);
                        end
                    end
                end
                VERIFY: begin
                    pos_nxt = pos_inc;
                    if (pos == '0) begin
                        if (sync_hit) begin
                            if (good_cnt == GOOD_LAST) begin
                                state_nxt = LOCK;
                                fwd       = 1'b1;
                                psync     = 1'b1;
                                bad_nxt   = '0;
                                good_nxt  = '0;
                            end else begin
                                good_nxt = good_cnt + 1'b1;
                            end
                        end else begin
                            state_nxt = HUNT;
                            pos_nxt   = '0;
                            good_nxt  = '0;
                        end
                    end
                end
                LOCK: begin
                    pos_nxt = pos_inc;
                    fwd     = 1'b1;
                    if (pos == '0) begin
                        if (sync_hit) begin
                            bad_nxt = '0;
                            psync   = 1'b1;
                        end else if (bad_cnt == BAD_LAST) begin
                            state_nxt = HUNT;
                            fwd       = 1'b0;
                            pos_nxt   = '0;
                            bad_nxt   = '0;
                        end else begin
                            // Flywheel: keep the interleaver commutator aligned.
                            bad_nxt = bad_cnt + 1'b1;
                            psync   = 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = HUNT;
                    pos_nxt   = '0;
                end
            endcase
        end
    end

    // Stage p1: registered interleaver-facing outputs, one cycle after accept.
    always_ff @(posedge iClk or negedge iClrn) begin
        if (!iClrn) begin
            data_p1  <= '0;
            vld_p1   <= 1'b0;
            psync_p1 <= 1'b0;
            lock_p1  <= 1'b0;
        end else begin
            vld_p1   <= fwd;
            psync_p1 <= psync;
            lock_p1  <= (state_nxt == LOCK);
            if (fwd) begin
                data_p1 <= iData;
            end
        end
    end

    assign oReady = ready;
    assign oData  = data_p1;
    assign oValid = vld_p1;
    assign oPSync = psync_p1;
    assign oLock  = lock_p1;

`ifdef INTLV_SYNC_CTRL_STATS_EN
    logic [15:0] pkt_cnt;
    logic [7:0]  loss_cnt;
    logic        loss_evt;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign loss_evt = (state == LOCK) && (state_nxt == HUNT);

    always_ff @(posedge iClk or negedge iClrn) begin
        if (!iClrn) begin
            pkt_cnt  <= '0;
            loss_cnt <= '0;
        end else begin
            if (psync) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
            if (loss_evt) begin
                loss_cnt <= sat_inc8(loss_cnt);
            end
        end
    end

    assign oPktCnt  = pkt_cnt;
    assign oLossCnt = loss_cnt;
`endif

endmodule

// File: tb/tb_intlv_sync_ctrl.sv
// Directed bench for intlv_sync_ctrl: main instance (RATE_DIV=4, LOCK_N=3)
// plus a fast instance (RATE_DIV=1, LOCK_N=1) for the boundary settings.
module tb_intlv_sync_ctrl;

    logic       iClk = 1'b0;
    logic       iClrn;
    logic [7:0] iData;
    logic       iValid;
    logic       oReady, oValid, oPSync, oLock;
    logic [7:0] oData;
    logic [7:0] iData1;
    logic       iValid1;
    logic       oReady1, oValid1, oPSync1, oLock1;
    logic [7:0] oData1;
`ifdef INTLV_SYNC_CTRL_STATS_EN
    logic [15:0] oPktCnt, oPktCnt1;
    logic [7:0]  oLossCnt, oLossCnt1;
`endif

    int checks = 0;
    int errors = 0;
    int stray_v = 0;

    logic       obs_v, obs_ps, obs_lk;
    logic [7:0] obs_d;
    logic       first_v, first_ps, first_lk, last_lk;
    logic [7:0] first_d;
    int         rest_v, rest_ps, data_err;

    always #5 iClk = ~iClk;

    intlv_sync_ctrl #(
        .PKT_LEN(204), .SYNC_BYTE(8'h47), .SYNC_INV(8'hB8),
        .LOCK_N(3), .UNLOCK_N(3), .RATE_DIV(4)
    ) dut (
        .iClk(iClk), .iClrn(iClrn), .iData(iData), .iValid(iValid),
        .oReady(oReady), .oData(oData), .oValid(oValid), .oPSync(oPSync),
        .oLock(oLock)
`ifdef INTLV_SYNC_CTRL_STATS_EN
        , .oPktCnt(oPktCnt), .oLossCnt(oLossCnt)
`endif
    );

    intlv_sync_ctrl #(
        .PKT_LEN(204), .SYNC_BYTE(8'h47), .SYNC_INV(8'hB8),
        .LOCK_N(1), .UNLOCK_N(3), .RATE_DIV(1)
    ) dut_fast (
        .iClk(iClk), .iClrn(iClrn), .iData(iData1), .iValid(iValid1),
        .oReady(oReady1), .oData(oData1), .oValid(oValid1), .oPSync(oPSync1),
        .oLock(oLock1)
`ifdef INTLV_SYNC_CTRL_STATS_EN
        , .oPktCnt(oPktCnt1), .oLossCnt(oLossCnt1)
`endif
    );

    // Waits for a ready window, offers one byte, samples the result at the next negedge.
    task automatic push_byte(input logic [7:0] b);
        int n;
        n = 0;
        while (oReady !== 1'b1 && n < 16) begin
            @(negedge iClk);
            n++;
            if (oValid === 1'b1) stray_v++;
        end
        if (n >= 16) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: oReady=%b after %0d cycles, required 1", oReady, n);
        end
        iData  = b;
        iValid = 1'b1;
        @(negedge iClk);
        obs_v  = oValid;
        obs_ps = oPSync;
        obs_d  = oData;
        obs_lk = oLock;
        iValid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] sb, input bit pat,
                            input int stray_pos, input logic [7:0] stray_val);
        logic [7:0] b;
        push_byte(sb);
        first_v  = obs_v;
        first_ps = obs_ps;
        first_d  = obs_d;
        first_lk = obs_lk;
        rest_v   = 0;
        rest_ps  = 0;
        data_err = 0;
        for (int p = 1; p < 204; p++) begin
            b = (p == stray_pos) ? stray_val : (pat ? 8'(p % 64 + 1) : 8'h00);
            push_byte(b);
            if (obs_v === 1'b1) rest_v++;
            if (obs_ps === 1'b1) rest_ps++;
            if (obs_v === 1'b1 && obs_d !== b) data_err++;
            last_lk = obs_lk;
        end
    endtask

    task automatic test_reset;
        iClrn = 1'b0; iValid = 1'b0; iData = 8'h00; iValid1 = 1'b0; iData1 = 8'h00;
        repeat (3) @(negedge iClk);
        checks++;
        if ({oReady, oValid, oPSync, oLock, oData} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got rdy/v/ps/lk/d=%b%b%b%b/%h, required 0000/00",
                     oReady, oValid, oPSync, oLock, oData);
        end
        checks++;
        if ({oReady1, oValid1, oPSync1, oLock1, oData1} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs_fast: got %b%b%b%b/%h, required 0000/00",
                     oReady1, oValid1, oPSync1, oLock1, oData1);
        end
`ifdef INTLV_SYNC_CTRL_STATS_EN
        checks++;
        if ({oPktCnt, oLossCnt} !== 24'h0) begin
            errors++;
            $display("FAIL reset_stats: got pkt=%0d loss=%0d, required 0 0", oPktCnt, oLossCnt);
        end
`endif
        iClrn = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge iClk);
            checks++;
            if (oReady !== ((i % 4) == 0)) begin
                errors++;
                $display("FAIL pace_ready[%0d]: got %b, required %b", i, oReady, (i % 4) == 0);
            end
            checks++;
            if (oReady1 !== 1'b1) begin
                errors++;
                $display("FAIL pace_ready_fast[%0d]: got %b, required 1", i, oReady1);
            end
        end
    endtask

    task automatic test_fast_boundary;
        iData1 = 8'h47; iValid1 = 1'b1;
        @(negedge iClk);
        checks++;
        if ({oValid1, oPSync1, oLock1, oData1} !== {3'b111, 8'h47}) begin
            errors++;
            $display("FAIL fast_lock1: got v/ps/lk/d=%b%b%b/%h, required 111/47",
                     oValid1, oPSync1, oLock1, oData1);
        end
        iData1 = 8'h05;
        @(negedge iClk);
        checks++;
        if ({oValid1, oPSync1, oLock1, oData1} !== {3'b101, 8'h05}) begin
            errors++;
            $display("FAIL fast_payload: got v/ps/lk/d=%b%b%b/%h, required 101/05",
                     oValid1, oPSync1, oLock1, oData1);
        end
        iValid1 = 1'b0;
        @(negedge iClk);
        checks++;
        if ({oValid1, oData1} !== {1'b0, 8'h05}) begin
            errors++;
            $display("FAIL fast_hold: got v/d=%b/%h, required 0/05", oValid1, oData1);
        end
    endtask

    task automatic test_lock_acquire;
        stray_v = 0;
        for (int k = 1; k <= 2; k++) begin
            send_pkt(8'h47, 1'b0, -1, 8'h00);
            checks++;
            if (first_v !== 1'b0 || rest_v != 0 || last_lk !== 1'b0) begin
                errors++;
                $display("FAIL acq_pkt%0d_quiet: got v0=%b nv=%0d lk=%b, required 0 0 0",
                         k, first_v, rest_v, last_lk);
            end
        end
        send_pkt(8'h47, 1'b0, -1, 8'h00);
        checks++;
        if ({first_v, first_ps, first_lk, first_d} !== {3'b111, 8'h47}) begin
            errors++;
            $display("FAIL acq_pkt3_sync: got v/ps/lk/d=%b%b%b/%h, required 111/47",
                     first_v, first_ps, first_lk, first_d);
        end
        checks++;
        if (rest_v != 203 || rest_ps != 0 || data_err != 0) begin
            errors++;
            $display("FAIL acq_pkt3_body: got nv=%0d nps=%0d derr=%0d, required 203 0 0",
                     rest_v, rest_ps, data_err);
        end
        send_pkt(8'h47, 1'b1, -1, 8'h00);
        checks++;
        if ({first_v, first_ps, first_d} !== {2'b11, 8'h47} || rest_v != 203 || data_err != 0) begin
            errors++;
            $display("FAIL acq_pkt4: got v/ps/d=%b%b/%h nv=%0d derr=%0d, required 11/47 203 0",
                     first_v, first_ps, first_d, rest_v, data_err);
        end
        checks++;
        if (stray_v != 0) begin
            errors++;
            $display("FAIL acq_single_pulse: got %0d stray valid cycles, required 0", stray_v);
        end
    endtask

    task automatic test_flywheel;
        logic [7:0] seq [5] = '{8'h12, 8'h47, 8'h12, 8'h12, 8'h47};
        for (int k = 0; k < 5; k++) begin
            send_pkt(seq[k], 1'b1, -1, 8'h00);
            checks++;
            if ({first_v, first_ps, first_lk, first_d} !== {3'b111, seq[k]} || last_lk !== 1'b1) begin
                errors++;
                $display("FAIL flywheel_pkt%0d: got v/ps/lk/d=%b%b%b/%h lk_end=%b, required 111/%h 1",
                         k, first_v, first_ps, first_lk, first_d, last_lk, seq[k]);
            end
            checks++;
            if (rest_v != 203 || rest_ps != 0 || data_err != 0) begin
                errors++;
                $display("FAIL flywheel_body%0d: got nv=%0d nps=%0d derr=%0d, required 203 0 0",
                         k, rest_v, rest_ps, data_err);
            end
        end
    endtask

    task automatic test_unlock;
        stray_v = 0;
        for (int k = 0; k < 2; k++) begin
            send_pkt(8'h12, 1'b1, -1, 8'h00);
            checks++;
            if ({first_v, first_ps, first_lk} !== 3'b111 || last_lk !== 1'b1) begin
                errors++;
                $display("FAIL unlock_miss%0d: got v/ps/lk=%b%b%b lk_end=%b, required 111 1",
                         k, first_v, first_ps, first_lk, last_lk);
            end
        end
        send_pkt(8'h12, 1'b1, -1, 8'h00);
        checks++;
        if ({first_v, first_ps, first_lk} !== 3'b000) begin
            errors++;
            $display("FAIL unlock_third: got v/ps/lk=%b%b%b, required 000", first_v, first_ps, first_lk);
        end
        checks++;
        if (rest_v != 0 || last_lk !== 1'b0 || stray_v != 0) begin
            errors++;
            $display("FAIL unlock_quiet: got nv=%0d lk=%b stray=%0d, required 0 0 0", rest_v, last_lk, stray_v);
        end
    endtask

    task automatic test_mixed_sync;
        send_pkt(8'hB8, 1'b1, -1, 8'h00);
        checks++;
        if (first_v !== 1'b0 || rest_v != 0) begin
            errors++;
            $display("FAIL mixed_pkt1: got v0=%b nv=%0d, required 0 0", first_v, rest_v);
        end
        send_pkt(8'h47, 1'b1, 100, 8'h47);
        checks++;
        if (first_v !== 1'b0 || rest_v != 0 || last_lk !== 1'b0) begin
            errors++;
            $display("FAIL mixed_pkt2_stray: got v0=%b nv=%0d lk=%b, required 0 0 0", first_v, rest_v, last_lk);
        end
        send_pkt(8'h47, 1'b1, -1, 8'h00);
        checks++;
        if ({first_v, first_ps, first_lk, first_d} !== {3'b111, 8'h47} || rest_v != 203) begin
            errors++;
            $display("FAIL mixed_pkt3_lock: got v/ps/lk/d=%b%b%b/%h nv=%0d, required 111/47 203",
                     first_v, first_ps, first_lk, first_d, rest_v);
        end
        send_pkt(8'hB8, 1'b1, -1, 8'h00);
        checks++;
        if ({first_v, first_ps, first_d} !== {2'b11, 8'hB8} || rest_ps != 0) begin
            errors++;
            $display("FAIL mixed_pkt4_inv: got v/ps/d=%b%b/%h nps=%0d, required 11/b8 0",
                     first_v, first_ps, first_d, rest_ps);
        end
    endtask

    task automatic test_midreset;
        send_pkt(8'h47, 1'b1, -1, 8'h00);
        push_byte(8'h47);
        checks++;
        if ({obs_v, obs_ps, obs_lk} !== 3'b111) begin
            errors++;
            $display("FAIL midrst_pre: got v/ps/lk=%b%b%b, required 111", obs_v, obs_ps, obs_lk);
        end
`ifdef INTLV_SYNC_CTRL_STATS_EN
        checks++;
        if (oPktCnt !== 16'd13 || oLossCnt !== 8'd1) begin
            errors++;
            $display("FAIL stats_pre: got pkt=%0d loss=%0d, required 13 1", oPktCnt, oLossCnt);
        end
`endif
        iClrn = 1'b0;
        #1;
        checks++;
        if ({oValid, oPSync, oLock, oReady} !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_async: got v/ps/lk/rdy=%b%b%b%b, required 0000", oValid, oPSync, oLock, oReady);
        end
        repeat (2) @(negedge iClk);
        iClrn = 1'b1;
`ifdef INTLV_SYNC_CTRL_STATS_EN
        checks++;
        if (oPktCnt !== 16'd0 || oLossCnt !== 8'd0) begin
            errors++;
            $display("FAIL stats_post: got pkt=%0d loss=%0d, required 0 0", oPktCnt, oLossCnt);
        end
`endif
        send_pkt(8'h47, 1'b1, -1, 8'h00);
        send_pkt(8'h12, 1'b1, -1, 8'h00);
        checks++;
        if (first_v !== 1'b0 || rest_v != 0) begin
            errors++;
            $display("FAIL rehunt_drop: got v0=%b nv=%0d, required 0 0", first_v, rest_v);
        end
        send_pkt(8'h47, 1'b1, -1, 8'h00);
        send_pkt(8'h47, 1'b1, -1, 8'h00);
        checks++;
        if (first_v !== 1'b0 || rest_v != 0) begin
            errors++;
            $display("FAIL rehunt_verify: got v0=%b nv=%0d, required 0 0", first_v, rest_v);
        end
        send_pkt(8'h47, 1'b1, -1, 8'h00);
        checks++;
        if ({first_v, first_ps, first_lk} !== 3'b111 || rest_v != 203) begin
            errors++;
            $display("FAIL rehunt_lock: got v/ps/lk=%b%b%b nv=%0d, required 111 203",
                     first_v, first_ps, first_lk, rest_v);
        end
    endtask

    initial begin
        test_reset();
        test_fast_boundary();
        test_lock_acquire();
        test_flywheel();
        test_unlock();
        test_mixed_sync();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
